// File: rtl/robot_world_responder_pkg.sv
// Shared definitions for the world-side responder of the pipe-cleaning robot.
// Holds the orientation codes (also used by the robot testbench), the map cell
// codes, the responder FSM encoding, the trash removal status codes and a few
// small helpers for orientation stepping and cell classification.
package robot_world_responder_pkg;

  typedef enum logic [3:0] {
    ORIENT_N = 4'd0,
    ORIENT_S = 4'd1,
    ORIENT_E = 4'd2,
    ORIENT_W = 4'd3
  } orient_e;

  typedef enum logic [2:0] {
    CELL_FREE   = 3'd0,
    CELL_WALL   = 3'd1,
    CELL_TRASH1 = 3'd2,
    CELL_TRASH2 = 3'd3,
    CELL_TRASH3 = 3'd4,
    CELL_UNDER  = 3'd5
  } cell_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RD_HEAD,
    ST_RD_LEFT,
    ST_RD_UNDER,
    ST_FIN
  } state_e;

  typedef enum logic [1:0] {
    TRS_NONE     = 2'b00,
    TRS_NO_TRASH = 2'b01,
    TRS_LOWERING = 2'b10,
    TRS_CLEARED  = 2'b11
  } trs_e;

  // Clockwise rotation N->E->S->W->N.
  function automatic orient_e turn_cw(input orient_e o);
    case (o)
      ORIENT_N: return ORIENT_E;
      ORIENT_E: return ORIENT_S;
      ORIENT_S: return ORIENT_W;
      default:  return ORIENT_N;
    endcase
  endfunction

  // Counter-clockwise rotation gives the direction of the robot's left side.
  function automatic orient_e turn_ccw(input orient_e o);
    case (o)
      ORIENT_N: return ORIENT_W;
      ORIENT_W: return ORIENT_S;
      ORIENT_S: return ORIENT_E;
      default:  return ORIENT_N;
    endcase
  endfunction

  function automatic logic is_trash(input cell_e c);
    return (c == CELL_TRASH1) || (c == CELL_TRASH2) || (c == CELL_TRASH3);
  endfunction

  // True when two or more of {front, turn, remove} are set.
  function automatic logic multi_hot(input logic [2:0] c);
    return (c[2] & c[1]) | (c[2] & c[0]) | (c[1] & c[0]);
  endfunction

endpackage

// File: rtl/robot_world_responder_if.sv
// Map RAM bus between the world responder and the map RAM.
// map_addr/map_we/map_wdata travel from the responder (master) to the RAM
// (slave); map_rdata returns with one cycle of synchronous read latency.
interface robot_world_responder_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] map_addr;
  logic [2:0]        map_rdata;
  logic              map_we;
  logic [2:0]        map_wdata;

  modport master (output map_addr, map_we, map_wdata, input map_rdata);
  modport slave  (input map_addr, map_we, map_wdata, output map_rdata);
endinterface

// File: rtl/robot_world_responder_neighbour_calc.sv
// world_neighbour_calc: combinational neighbour finder.
// Inputs : row, col (1-based pose), orient (robot heading).
// Outputs: front_row/front_col (cell ahead), left_row/left_col (cell on the
//          left), front_oob/left_oob (neighbour lies outside 1..ROWS/1..COLS).
module world_neighbour_calc
  import robot_world_responder_pkg::*;
#(
  parameter int ROWS = 10,
  parameter int COLS = 20
) (
  input  logic [4:0] row,
  input  logic [4:0] col,
  input  orient_e    orient,
  output logic [4:0] front_row,
  output logic [4:0] front_col,
  output logic [4:0] left_row,
  output logic [4:0] left_col,
  output logic       front_oob,
  output logic       left_oob
);

  localparam logic [4:0] ROWS_L = 5'(ROWS);
  localparam logic [4:0] COLS_L = 5'(COLS);

  // Stepping off row/col 1 yields 0, which is caught by the bounds test below.
  function automatic logic [9:0] step_cell(input logic [4:0] r, input logic [4:0] c,
                                           input orient_e o);
    case (o)
      ORIENT_N: return {r - 5'd1, c};
      ORIENT_S: return {r + 5'd1, c};
      ORIENT_E: return {r, c + 5'd1};
      default:  return {r, c - 5'd1};
    endcase
  endfunction

  always_comb begin
    {front_row, front_col} = step_cell(row, col, orient);
    {left_row, left_col}   = step_cell(row, col, turn_ccw(orient));
    front_oob = (front_row == 5'd0) || (front_row > ROWS_L) ||
                (front_col == 5'd0) || (front_col > COLS_L);
    left_oob  = (left_row == 5'd0) || (left_row > ROWS_L) ||
                (left_col == 5'd0) || (left_col > COLS_L);
  end

endmodule

// File: rtl/robot_world_responder.sv
// robot_world_responder: world-side responder for the pipe-cleaning robot.
// On each robot_tick it executes one command (front/turn/remove) against the
// cached front cell, writes lowered trash back to the map RAM, then re-reads
// the front, left and current cells to refresh the four sensors.
// Ports:
//   clock_50, reset_key (async, active-low)
//   robot_tick, front, turn, remove    : command strobe and command bits
//   map_bus (master)                   : map RAM address/write/read bus
//   head, left, barrier, under         : registered sensors
//   sensors_valid                      : sensors match the current pose
//   robot_row/column/orientation       : pose
//   trash_removal_state                : result of the last remove
//   cmd_error, collision, overrun      : one-cycle status pulses
module robot_world_responder
  import robot_world_responder_pkg::*;
#(
  parameter int ROWS     = 10,
  parameter int COLS     = 20,
  parameter int ROW_INIT = 1,
  parameter int COL_INIT = 1,
  parameter int ADDR_W   = 8
) (
  input  logic       clock_50,
  input  logic       reset_key,
  input  logic       robot_tick,
  input  logic       front,
  input  logic       turn,
  input  logic       remove,
  robot_world_responder_if.master map_bus,
  output logic       head,
  output logic       left,
  output logic       barrier,
  output logic       under,
  output logic       sensors_valid,
  output logic [4:0] robot_row,
  output logic [4:0] robot_column,
  output logic [3:0] robot_orientation,
  output logic [1:0] trash_removal_state,
  output logic       cmd_error,
  output logic       collision,
  output logic       overrun
);

  state_e      state_q, state_d;
  logic [4:0]  row_q, row_d, col_q, col_d;
  orient_e     orient_q, orient_d;
  cell_e       front_cell_q, front_cell_d;
  logic        left_wall_q, left_wall_d;
  logic        head_q, head_d, left_q, left_d, barrier_q, barrier_d, under_q, under_d;
  logic        valid_q, valid_d;
  trs_e        trs_q, trs_d;
  logic        cmd_error_q, cmd_error_d, collision_q, collision_d, overrun_q, overrun_d;
  logic        map_we_q, map_we_d;
  logic [2:0]  map_wdata_q, map_wdata_d;
  logic [2:0]  cmd_q, cmd_d;

  logic [4:0]  front_row, front_col, left_row, left_col;
  logic        front_oob, left_oob;
  logic [ADDR_W-1:0] map_addr;
  cell_e       rd_cell;

  world_neighbour_calc #(.ROWS(ROWS), .COLS(COLS)) u_neighbour (
    .row       (row_q),
    .col       (col_q),
    .orient    (orient_q),
    .front_row (front_row),
    .front_col (front_col),
    .left_row  (left_row),
    .left_col  (left_col),
    .front_oob (front_oob),
    .left_oob  (left_oob)
  );

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [4:0] r, input logic [4:0] c);
    logic [ADDR_W-1:0] r0, c0;
    r0 = ADDR_W'(r) - ADDR_W'(1);
    c0 = ADDR_W'(c) - ADDR_W'(1);
    return r0 * ADDR_W'(COLS) + c0;
  endfunction

  // EXEC shares the front address with RD_HEAD so a remove write lands on the
  // cell ahead; RD_UNDER and the idle states point at the current cell.
  always_comb begin
    case (state_q)
      ST_EXEC, ST_RD_HEAD: map_addr = cell_addr(front_row, front_col);
      ST_RD_LEFT:          map_addr = cell_addr(left_row, left_col);
      default:             map_addr = cell_addr(row_q, col_q);
    endcase
  end

  assign rd_cell = cell_e'(map_bus.map_rdata);

  // Next-state logic. The write is decided at tick acceptance so map_we is high
  // during EXEC and the following RD_HEAD read already sees the lowered trash.
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    orient_d     = orient_q;
    front_cell_d = front_cell_q;
    left_wall_d  = left_wall_q;
    head_d       = head_q;
    left_d       = left_q;
    barrier_d    = barrier_q;
    under_d      = under_q;
    valid_d      = valid_q;
    trs_d        = trs_q;
    cmd_d        = cmd_q;
    map_wdata_d  = map_wdata_q;
    map_we_d     = 1'b0;
    cmd_error_d  = 1'b0;
    collision_d  = 1'b0;
    overrun_d    = robot_tick && (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (robot_tick) begin
          state_d = ST_EXEC;
          valid_d = 1'b0;
          cmd_d   = {front, turn, remove};
          if (remove && !multi_hot({front, turn, remove}) && is_trash(front_cell_q)) begin
            map_we_d    = 1'b1;
            map_wdata_d = (front_cell_q == CELL_TRASH1) ? CELL_FREE : front_cell_q - 3'd1;
          end
        end
      end
      ST_EXEC: begin
        state_d = ST_RD_HEAD;
        trs_d   = TRS_NONE;
        if (multi_hot(cmd_q)) begin
          cmd_error_d = 1'b1;
        end else if (cmd_q[2]) begin
          if (front_cell_q == CELL_FREE || front_cell_q == CELL_UNDER) begin
            row_d = front_row;
            col_d = front_col;
          end else begin
            collision_d = 1'b1;
          end
        end else if (cmd_q[1]) begin
          orient_d = turn_cw(orient_q);
        end else if (cmd_q[0]) begin
          if (!is_trash(front_cell_q))
            trs_d = TRS_NO_TRASH;
          else if (front_cell_q == CELL_TRASH1)
            trs_d = TRS_CLEARED;
          else
            trs_d = TRS_LOWERING;
        end
      end
      ST_RD_HEAD: state_d = ST_RD_LEFT;
      ST_RD_LEFT: begin
        state_d      = ST_RD_UNDER;
        front_cell_d = front_oob ? CELL_WALL : rd_cell;
      end
      ST_RD_UNDER: begin
        state_d     = ST_FIN;
        left_wall_d = left_oob || (rd_cell == CELL_WALL);
      end
      ST_FIN: begin
        state_d   = ST_IDLE;
        head_d    = (front_cell_q == CELL_WALL);
        barrier_d = is_trash(front_cell_q);
        left_d    = left_wall_q;
        under_d   = (rd_cell == CELL_UNDER);
        valid_d   = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset drops any pending write and restarts with a full sensor refresh.
  always_ff @(posedge clock_50 or negedge reset_key) begin
    if (!reset_key) begin
      state_q      <= ST_RD_HEAD;
      row_q        <= 5'(ROW_INIT);
      col_q        <= 5'(COL_INIT);
      orient_q     <= ORIENT_N;
      front_cell_q <= CELL_FREE;
      left_wall_q  <= 1'b0;
      head_q       <= 1'b0;
      left_q       <= 1'b0;
      barrier_q    <= 1'b0;
      under_q      <= 1'b0;
      valid_q      <= 1'b0;
      trs_q        <= TRS_NONE;
      cmd_q        <= 3'b000;
      map_wdata_q  <= 3'b000;
      map_we_q     <= 1'b0;
      cmd_error_q  <= 1'b0;
      collision_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      orient_q     <= orient_d;
      front_cell_q <= front_cell_d;
      left_wall_q  <= left_wall_d;
      head_q       <= head_d;
      left_q       <= left_d;
      barrier_q    <= barrier_d;
      under_q      <= under_d;
      valid_q      <= valid_d;
      trs_q        <= trs_d;
      cmd_q        <= cmd_d;
      map_wdata_q  <= map_wdata_d;
      map_we_q     <= map_we_d;
      cmd_error_q  <= cmd_error_d;
      collision_q  <= collision_d;
      overrun_q    <= overrun_d;
    end
  end

  assign map_bus.map_addr    = map_addr;
  assign map_bus.map_we      = map_we_q;
  assign map_bus.map_wdata   = map_wdata_q;
  assign head                = head_q;
  assign left                = left_q;
  assign barrier             = barrier_q;
  assign under               = under_q;
  assign sensors_valid       = valid_q;
  assign robot_row           = row_q;
  assign robot_column        = col_q;
  assign robot_orientation   = orient_q;
  assign trash_removal_state = trs_q;
  assign cmd_error           = cmd_error_q;
  assign collision           = collision_q;
  assign overrun             = overrun_q;

endmodule
